ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage. It sits directly downstream of the second operand handler and consumes the rs1 value and the handler's N output for UMUL/SMUL/UDIV/SDIV. It owns the Y register, which receives the high product word or the remainder. The pipeline is held on `busy` until a one-cycle `done` pulse delivers the result.

---
 rtl/ex_muldiv.sv | 204 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative 32-bit multiply/divide unit for the EX stage.
//
// Runs UMUL/SMUL (shift-add into a 64-bit accumulator) and UDIV/SDIV
// (restoring division) one bit per cycle over 32 CALC cycles, then a FIX
// cycle applies the sign correction and writes result/y. Owns the Y
// register, which also accepts WRY writes while idle.
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// UDIV/SDIV finish in one FIX cycle and pulse unimp with result=0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op[1:0]    launch request and opcode (00 UMUL, 01 SMUL,
//                     10 UDIV, 11 SDIV), sampled while busy=0
//   a[31:0], n[31:0]  rs1 value and second operand
//   flush             synchronous abort back to IDLE, no done
//   y_we, y_wdata     WRY write into Y, honoured only while idle
//   busy              operation in flight (pipeline stall)
//   done              one-cycle pulse, result and y valid
//   result[31:0]      low product word or quotient
//   y[31:0]           Y register: high product word or remainder
//   div_zero          pulses with done when a divide had n==0
//   unimp             pulses with done when the op is not built in
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] n,
  input  logic        flush,
  input  logic        y_we,
  input  logic [31:0] y_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] y,
  output logic        div_zero,
  output logic        unimp
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;       // {high/remainder, low/quotient} working register
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic        neg_lo;    // product / quotient must be negated in FIX
  logic        is_div, a_neg, n_neg, short_op;
  logic [31:0] a_mag, n_mag;
  logic [32:0] mul_sum;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] fix_result, fix_y;
`ifdef MULDIV_DIV_EN
  logic        is_div_q, neg_hi, dz_q;
  logic [32:0] div_part;
  logic        div_ge;
  logic [31:0] div_rem;
`else
  logic        unimp_q;
`endif

  assign is_div = op[1];
  assign a_neg  = op[0] & a[31];
  assign n_neg  = op[0] & n[31];
  assign a_mag  = a_neg ? -a : a;
  assign n_mag  = n_neg ? -n : n;
  assign busy   = (state != IDLE);

  // Ops that skip CALC and go straight to FIX.
`ifdef MULDIV_DIV_EN
  assign short_op = is_div & (n == 32'd0);
`else
  assign short_op = is_div;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = short_op ? FIX : CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // One iteration. Multiply: add multiplicand into the high half when the
  // current multiplier bit (acc[0]) is set, then shift right with carry.
  // Divide: shift the remainder:dividend pair left, trial-subtract the
  // divisor, and shift in the quotient bit.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    acc_step = {mul_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
    div_part = acc[63:31];
    div_ge   = (div_part >= {1'b0, opnd});
    // When div_ge, the true difference is below opnd, so 32 bits hold it.
    div_rem  = div_ge ? (div_part[31:0] - opnd) : div_part[31:0];
    if (is_div_q) acc_step = {div_rem, acc[30:0], div_ge};
`endif
  end

  // Sign correction: multiply negates the full 64-bit product; divide
  // negates quotient and remainder independently.
  always_comb begin
    prod_fix   = neg_lo ? (~acc + 64'd1) : acc;
    fix_result = prod_fix[31:0];
    fix_y      = prod_fix[63:32];
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      fix_result = neg_lo ? -acc[31:0]  : acc[31:0];
      fix_y      = neg_hi ? -acc[63:32] : acc[63:32];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset along with control so result/y
      // and the accumulator read as defined values straight out of reset.
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_lo   <= 1'b0;
      result   <= '0;
      y        <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      unimp    <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      neg_hi   <= 1'b0;
      dz_q     <= 1'b0;
`else
      unimp_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      state    <= state_nxt;
      done     <= 1'b0;
      div_zero <= 1'b0;
      unimp    <= 1'b0;
      if (state == IDLE && y_we) y <= y_wdata;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            cnt    <= '0;
            neg_lo <= a_neg ^ n_neg;
            if (is_div) begin
              acc  <= {32'd0, a_mag};
              opnd <= n_mag;
            end else begin
              acc  <= {32'd0, n_mag};
              opnd <= a_mag;
            end
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div;
            neg_hi   <= a_neg;
            dz_q     <= short_op;
            // Divide by zero returns the raw dividend in y.
            if (short_op) acc <= {32'd0, a};
`else
            unimp_q  <= short_op;
`endif
          end
          CALC: begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
          end
          FIX: begin
            done <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (dz_q) begin
              result   <= '1;
              y        <= acc[31:0];
              div_zero <= 1'b1;
            end else begin
              result <= fix_result;
              y      <= fix_y;
            end
`else
            if (unimp_q) begin
              result <= '0;
              unimp  <= 1'b1;
            end else begin
              result <= fix_result;
              y      <= fix_y;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv -- scoreboard bench for ex_muldiv.
// Stimulus pushes hand-computed expectations into a queue; a monitor pops
// and compares on every done pulse. Expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, y_we;
  logic [1:0]  op;
  logic [31:0] a, n, y_wdata;
  logic        busy, done, div_zero, unimp;
  logic [31:0] result, y;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .n(n),
    .flush(flush), .y_we(y_we), .y_wdata(y_wdata), .busy(busy),
    .done(done), .result(result), .y(y), .div_zero(div_zero), .unimp(unimp)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] yv;
    logic        dz;
    logic        un;
  } exp_t;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int MUL_LAT = 34;
  localparam int DIV_LAT = DIV_EN ? 34 : 2;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] y_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic [31:0] yv,
                              input logic dz, input logic un);
    exp_t e;
    e.res = res; e.yv = yv; e.dz = dz; e.un = un;
    return e;
  endfunction

  // Division expectation: without the divider, result=0, y unchanged, unimp.
  function automatic exp_t mk_div(input logic [31:0] res, input logic [31:0] yv,
                                  input logic dz);
    return DIV_EN ? mk(res, yv, dz, 1'b0) : mk(32'd0, y_model, 1'b0, 1'b1);
  endfunction

  // Monitor: compare every done pulse against the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding, result=0x%0h y=0x%0h",
                 result, y);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("y", y, mon_e.yv);
        check("div_zero", {31'd0, div_zero}, {31'd0, mon_e.dz});
        check("unimp", {31'd0, unimp}, {31'd0, mon_e.un});
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle so a
  // following call starts in the done cycle (back-to-back launch).
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] nn, input exp_t e, input int lat);
    int cyc;
    bit seen;
    sb.push_back(e);
    y_model = e.yv;
    op = o; a = aa; n = nn; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({name, "_busy_c1"}, {31'd0, busy}, 32'd1);
      if (done) seen = 1'b1;
    end
    check({name, "_latency"}, cyc, lat);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; y_we = 1'b0;
    op = 2'b00; a = '0; n = '0; y_wdata = '0; y_model = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);
    check("rst_unimp", {31'd0, unimp}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_y", y, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply and divide vectors, issued back to back.
    run_op("umul_ff_x2", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, mk(32'hFFFF_FFFE, 32'h0000_0001, 0, 0), MUL_LAT);
    run_op("smul_m3_x7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, mk(32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 0), MUL_LAT);
    run_op("smul_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, mk(32'h0000_0000, 32'h4000_0000, 0, 0), MUL_LAT);
    run_op("umul_ff_sq", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h0000_0001, 32'hFFFF_FFFE, 0, 0), MUL_LAT);
    run_op("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, mk_div(32'hFFFF_FFFD, 32'hFFFF_FFFF, 0), DIV_LAT);
    run_op("sdiv_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, mk_div(32'h8000_0000, 32'h0000_0000, 0), DIV_LAT);
    run_op("udiv_100_7", 2'b10, 32'h0000_0064, 32'h0000_0007, mk_div(32'h0000_000E, 32'h0000_0002, 0), DIV_LAT);
    run_op("sdiv_7_m2", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, mk_div(32'hFFFF_FFFD, 32'h0000_0001, 0), DIV_LAT);
    run_op("udiv_by0", 2'b10, 32'h1234_5678, 32'h0000_0000, mk_div(32'hFFFF_FFFF, 32'h1234_5678, 1), 2);

    // WRY in IDLE.
    @(negedge clk);
    y_we = 1'b1; y_wdata = 32'hCAFE_BABE;
    @(negedge clk);
    y_we = 1'b0;
    check("wry_idle", y, 32'hCAFE_BABE);
    y_model = 32'hCAFE_BABE;

    // WRY held during busy is ignored; FIX write wins at the last edge.
    // A second start raised mid-operation must not launch anything.
    sb.push_back(mk(32'd6, 32'd0, 0, 0));
    op = 2'b00; a = 32'd2; n = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin y_we = 1'b1; y_wdata = 32'h1234_5678; end
      if (cyc == 5) begin start = 1'b1; op = 2'b11; a = 32'hFFFF_FFF9; n = 32'd2; end
      if (cyc == 6) start = 1'b0;
      if (cyc == 10) check("wry_busy_ignored", y, 32'hCAFE_BABE);
      if (done) seen = 1'b1;
    end
    y_we = 1'b0;
    check("wry_busy_latency", cyc, MUL_LAT);
    y_model = 32'd0;
    @(negedge clk);
    check("wry_after_fix", y, 32'd0);

    // Flush at cycle 10 of a multiply, then flush+start together in IDLE.
    op = 2'b00; a = 32'd5; n = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'd1; n = 32'd1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("flush_no_done", {31'd0, seen}, 32'd0);
    check("flush_result_kept", result, 32'd6);
    check("flush_y_kept", y, y_model);

    // Counter must restart cleanly after a flush.
    run_op("umul_after_flush", 2'b00, 32'h0001_0000, 32'h0001_0000, mk(32'h0000_0000, 32'h0000_0001, 0, 0), MUL_LAT);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    op = 2'b00; a = 32'd3; n = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_result", result, 32'd0);
    check("async_rst_y", y, 32'd0);
    y_model = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("umul_after_rst", 2'b00, 32'd7, 32'd6, mk(32'd42, 32'd0, 0, 0), MUL_LAT);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
